// File: rtl/disp_pkg.sv
// disp_pkg: shared encodings for the display channel scheduler.
package disp_pkg;
  localparam int CH_W = 3;
  typedef logic [CH_W-1:0] ch_t;
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_STEP   = 2'b10
  } mode_e;
  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LATCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/disp_next_ch.sv
// disp_next_ch: next enabled channel after cur, wrapping 7->0, cur itself last; 0 when mask is empty.
module disp_next_ch
  import disp_pkg::*;
(
  input  ch_t        cur,
  input  logic [7:0] mask,
  output ch_t        nxt
);
  logic [7:0] rot;
  ch_t        off;
  always_comb begin
    rot = 8'({mask, mask} >> (4'(cur) + 4'd1));
    off = 3'd7;
    for (int i = 6; i >= 0; i--) if (rot[i]) off = ch_t'(i);
    nxt = (mask == '0) ? '0 : cur + off + 3'd1;
  end
endmodule

// File: rtl/disp_channel_sched.sv
// disp_channel_sched: display mux channel sequencer with CPU-write preemption to channel 0.
module disp_channel_sched
  import disp_pkg::*;
#(
  parameter int DWELL_W  = 26,
  parameter int HOLD_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [2:0]         sw_sel,
  input  logic               step_pulse,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               cpu_wr_req,
  output logic               cpu_wr_ack,
  output logic               latch_en,
  output logic [2:0]         test_sel,
  output logic               hold_active
);
  localparam int HC_W = $clog2(HOLD_CYC + 1);
  state_e             state_q, state_d;
  ch_t                test_sel_q, test_sel_d, saved_ch_q, saved_ch_d, nxt;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d, dwell_max;
  logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [1:0]         mode_q;
  logic               req_armed_q, req_armed_d, latch_en_q, latch_en_d;
  logic               hold_active_q, hold_active_d;
  logic               is_auto, is_step, mode_chg, expire, req_go, hold_done;

  disp_next_ch u_next (.cur(test_sel_q), .mask(ch_mask), .nxt(nxt));

  assign is_auto   = mode == MODE_AUTO;
  assign is_step   = mode == MODE_STEP;
  assign mode_chg  = mode != mode_q;
  assign dwell_max = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign expire    = dwell_cnt_q >= dwell_max;
  assign req_go    = cpu_wr_req && req_armed_q;
  assign hold_done = hold_cnt_q == HC_W'(HOLD_CYC - 1);

  always_comb begin
    state_d     = state_q;
    test_sel_d  = test_sel_q;
    saved_ch_d  = saved_ch_q;
    dwell_cnt_d = dwell_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    req_armed_d = !cpu_wr_req ? 1'b1 : (state_q == S_LATCH) ? 1'b0 : req_armed_q;
    case (state_q)
      S_LATCH: begin
        state_d    = S_HOLD;
        hold_cnt_d = '0;
      end
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + HC_W'(1);
        if (req_go) state_d = S_LATCH;
        else if (hold_done) begin
          state_d    = S_RUN;
          test_sel_d = (is_auto || is_step) ? saved_ch_q : sw_sel;
        end
      end
      default: begin
        if (req_go) begin
          state_d    = S_LATCH;
          saved_ch_d = test_sel_q;
        end else begin
          // a mode change swallows that cycle's dwell expiry
          dwell_cnt_d = (!is_auto || mode_chg || expire) ? '0 : dwell_cnt_q + DWELL_W'(1);
          test_sel_d  = is_auto ? ((!mode_chg && expire) ? nxt : test_sel_q)
                      : is_step ? (step_pulse ? nxt : test_sel_q)
                      : sw_sel;
        end
      end
    endcase
    if (state_d != S_RUN) test_sel_d = '0;
    latch_en_d    = state_d == S_LATCH;
    hold_active_d = state_d != S_RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_RUN;
      test_sel_q    <= '0;
      saved_ch_q    <= '0;
      dwell_cnt_q   <= '0;
      hold_cnt_q    <= '0;
      mode_q        <= MODE_MANUAL;
      req_armed_q   <= 1'b1;
      latch_en_q    <= 1'b0;
      hold_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      test_sel_q    <= test_sel_d;
      saved_ch_q    <= saved_ch_d;
      dwell_cnt_q   <= dwell_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      mode_q        <= mode;
      req_armed_q   <= req_armed_d;
      latch_en_q    <= latch_en_d;
      hold_active_q <= hold_active_d;
    end
  end

  assign test_sel    = test_sel_q;
  assign latch_en    = latch_en_q;
  assign cpu_wr_ack  = latch_en_q;
  assign hold_active = hold_active_q;
endmodule

// File: tb/tb_disp_channel_sched.sv
// tb_disp_channel_sched: scoreboard bench for the display channel scheduler.
module tb_disp_channel_sched;
  import disp_pkg::*;
  localparam int HC = 16;
  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b0;
  logic [1:0]  mode = MODE_MANUAL;
  logic [2:0]  sw_sel = '0;
  logic        step_pulse = 1'b0, cpu_wr_req = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [25:0] dwell = '0;
  logic        cpu_wr_ack, latch_en, hold_active;
  logic [2:0]  test_sel;
  logic [5:0]  obs;
  int          n_chk = 0, n_fail = 0;
  exp_t        sb[$];
  int          seq[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 5, 7, 2};

  always #5 clk = ~clk;

  disp_channel_sched #(.DWELL_W(26), .HOLD_CYC(HC)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sw_sel(sw_sel), .step_pulse(step_pulse),
    .ch_mask(ch_mask), .dwell(dwell), .cpu_wr_req(cpu_wr_req), .cpu_wr_ack(cpu_wr_ack),
    .latch_en(latch_en), .test_sel(test_sel), .hold_active(hold_active)
  );

  assign obs = {hold_active, cpu_wr_ack, latch_en, test_sel};

  function automatic logic [5:0] pk(logic [2:0] ch, logic le, logic ack, logic ha);
    return {ha, ack, le, ch};
  endfunction

  task automatic check(string tag, logic [5:0] got, logic [5:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {hold,ack,latch,sel}=%b_%b_%b_%0d expected %b_%b_%b_%0d at %0t",
               tag, got[5], got[4], got[3], got[2:0], exp[5], exp[4], exp[3], exp[2:0], $time);
    end
  endtask

  task automatic cyc(string tag, logic [5:0] e);
    exp_t x;
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check(x.tag, obs, x.v);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset", obs, 6'd0);
    #4 rst = 1'b1;
    sw_sel = 3'd5;
    cyc("man5", pk(3'd5, 0, 0, 0));
    sw_sel = 3'd2;
    cyc("man2", pk(3'd2, 0, 0, 0));
    sw_sel = 3'd0;
    cyc("man0", pk(3'd0, 0, 0, 0));
    mode = MODE_AUTO;
    dwell = 26'd3;
    ch_mask = 8'hFF;
    for (int k = 0; k < 14; k++) begin
      if (k == 10) ch_mask = 8'hA4;
      repeat (3) cyc("auto", pk(3'(seq[k]), 0, 0, 0));
    end
    ch_mask = 8'h00;
    repeat (6) cyc("mask0", pk(3'd0, 0, 0, 0));
    dwell = 26'd0;
    ch_mask = 8'hFF;
    for (int i = 1; i <= 8; i++) cyc("dwell0", pk(3'(i), 0, 0, 0));
    mode = MODE_STEP;
    step_pulse = 1'b1;
    for (int i = 1; i <= 3; i++) cyc("step", pk(3'(i), 0, 0, 0));
    step_pulse = 1'b0;
    cyc("step_idle", pk(3'd3, 0, 0, 0));
    cpu_wr_req = 1'b1;
    for (int i = 0; i <= HC; i++) begin
      if (i == 5) cpu_wr_req = 1'b0;
      step_pulse = (i == 8);
      cyc(i == 0 ? "latch1" : "hold1", i == 0 ? pk(3'd0, 1, 1, 1) : pk(3'd0, 0, 0, 1));
    end
    step_pulse = 1'b0;
    cyc("restore1", pk(3'd3, 0, 0, 0));
    cpu_wr_req = 1'b1;
    step_pulse = 1'b1;
    cyc("latch2a", pk(3'd0, 1, 1, 1));
    cpu_wr_req = 1'b0;
    step_pulse = 1'b0;
    repeat (5) cyc("hold2a", pk(3'd0, 0, 0, 1));
    cpu_wr_req = 1'b1;
    cyc("latch2b", pk(3'd0, 1, 1, 1));
    cpu_wr_req = 1'b0;
    repeat (HC) cyc("hold2b", pk(3'd0, 0, 0, 1));
    cyc("restore2", pk(3'd3, 0, 0, 0));
    cpu_wr_req = 1'b1;
    cyc("latch3", pk(3'd0, 1, 1, 1));
    cpu_wr_req = 1'b0;
    repeat (3) cyc("hold3", pk(3'd0, 0, 0, 1));
    #2 rst = 1'b0;
    #1 check("rst_async", obs, 6'd0);
    #2 rst = 1'b1;
    repeat (3) cyc("post_rst", pk(3'd0, 0, 0, 0));
    cpu_wr_req = 1'b1;
    cyc("latch4", pk(3'd0, 1, 1, 1));
    cpu_wr_req = 1'b0;
    cyc("hold4", pk(3'd0, 0, 0, 1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
